modinv_operand_sequencer: RTL and testbench
===========================================

# modinv_operand_sequencer

Word-serial host-side sequencer for the 256-bit modular invertor core. Accepts a full-width operand A and modulus Q in parallel, writes them LSW-first into the core's A/Q operand BRAMs, pulses the core's enable, waits for ready, then reads the A⁻¹ result BRAM back into a parallel register. It sits between a register-mapped host (e.g. the CW305 target interface) and the invertor core with its three 32-bit BRAMs.

## Interface
Parameters:
- OPERAND_WIDTH, 256, operand width in bits; multiple of 32
- ADDR_BITS, 3, BRAM word address width; equals log2(OPERAND_WIDTH/32)
- TIMEOUT_CYCLES, 1048575, watchdog limit; used only with the timeout feature

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  request pulse; sampled only in IDLE
- a_in  in  OPERAND_WIDTH  operand A
- q_in  in  OPERAND_WIDTH  modulus Q
- busy  out  1  high from accepted start through the done cycle
- done  out  1  one-cycle completion pulse
- err  out  1  sticky timeout flag, cleared by next accepted start (0 without timeout feature)
- a1_out  out  OPERAND_WIDTH  result A⁻¹ mod Q, held until next accepted start
- aq_addr  out  ADDR_BITS  write address shared by A and Q BRAMs
- aq_wren  out  1  write enable for A and Q BRAMs
- a_wdata  out  32  A word
- q_wdata  out  32  Q word
- core_ena  out  1  one-cycle start pulse to core
- core_rdy  in  1  core idle/result-valid
- a1_addr  out  ADDR_BITS  result BRAM read address
- a1_rdata  in  32  result BRAM read data, registered, 1-cycle latency

## Operation
- States: IDLE, LOAD, KICK, ARM, WAIT, READ, DONE.
- IDLE: start=1 and core_rdy=1 → latch a_in/q_in into shift registers, clear err, busy=1, → LOAD. start while core_rdy=0 is ignored (protects a core still running after our reset).
- LOAD: word counter k=0..N-1 (N=OPERAND_WIDTH/32); aq_wren=1, aq_addr=k, a_wdata/q_wdata = bits [32k+31:32k]. After k=N-1 → KICK.
- KICK: aq_wren=0, core_ena=1 for exactly one cycle → ARM.
- ARM: one cycle, core_rdy ignored (core deasserts rdy the cycle after ena) → WAIT.
- WAIT: core_rdy=1 → READ.
- READ: a1_addr=r for r=0..N-1 on consecutive cycles; a1_rdata captured one cycle after each address into a1_out[32r+31:32r] (shift-in from MSW side); N+1 cycles total → DONE.
- DONE: done=1, busy=1 for one cycle → IDLE (busy=0 next cycle).
- start outside IDLE ignored; a_in/q_in changes after acceptance have no effect.
- Unused data/address outputs driven 0 when not active.

## Timing
- Reset: busy=0, done=0, err=0, a1_out=0, aq_wren=0, core_ena=0, aq_addr=0, a1_addr=0, a_wdata=0, q_wdata=0; state=IDLE. Reset mid-operation aborts immediately; core is not reset by this block.
- Start accepted at edge T0: LOAD writes at T1..TN; core_ena high in cycle TN+1; ARM TN+2; WAIT from TN+3.
- If core_rdy seen at cycle W: READ addresses W+1..W+N, last capture W+N+1, done=1 in cycle W+N+2.
- Fixed overhead excluding core compute: 2N+5 cycles (21 for N=8).
- core_rdy high already in ARM has no effect; first sample is in WAIT.

## Configuration
- MODINV_SEQ_TIMEOUT_EN defined: counter runs in ARM/WAIT; reaching TIMEOUT_CYCLES without core_rdy → err=1, done=1 for one cycle, a1_out unchanged, → IDLE.
- Not defined: no counter, WAIT indefinitely, err tied 0.

## Test plan
- Reset then start with A=d3e73ccd63a5b10da308c615bb9ebd3f76e2c5fccc256fd9f629dcc956bf2382, Q=ffffffff00000001000000000000000000000000ffffffffffffffffffffffff → done once, a1_out=93fb26d5d199bbb7232a4b7c98e97ba9bb7530d304b5f07736ea4027bbb57ecd, err=0.
- Back-to-back second run, A=57b6c628a5c4e870740b2517975ace2216acbe094ac54568b53212ef45e69d22 → a1_out=cd2af4766642d7d2f3f3f67d92c575c496772ef7d55c75eb46bd07e8d5f9a4aa; previous a1_out held until that start.
- Monitor BRAM ports: exactly 8 writes at addr 0..7, word0 of Q = ffffffff, word6 of Q = 00000001; exactly one core_ena pulse; 8 reads in order 0..7; done latency = core time + 21 cycles.
- start pulsed during WAIT and while core_rdy=0 in IDLE → ignored, no extra writes or ena.
- rst asserted mid-READ → all outputs at reset values next cycle; new start after core_rdy=1 yields correct result.
- With MODINV_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100, stub core holding core_rdy=0 → err=1 and done pulse at cycle 100 of WAIT, a1_out unchanged, busy=0 after.

Source files
------------

// File: rtl/modinv_operand_sequencer.sv
// Word-serial host sequencer for the 256-bit modular invertor core: loads A/Q BRAMs, kicks the core,
// waits for ready, then gathers the A^-1 result. Optional watchdog: define MODINV_SEQ_TIMEOUT_EN.
module modinv_operand_sequencer #(
  parameter int OPERAND_WIDTH  = 256,
  parameter int ADDR_BITS      = 3,
  parameter int TIMEOUT_CYCLES = 1048575
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [OPERAND_WIDTH-1:0] a_in,
  input  logic [OPERAND_WIDTH-1:0] q_in,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [OPERAND_WIDTH-1:0] a1_out,
  output logic [ADDR_BITS-1:0]     aq_addr,
  output logic                     aq_wren,
  output logic [31:0]              a_wdata,
  output logic [31:0]              q_wdata,
  output logic                     core_ena,
  input  logic                     core_rdy,
  output logic [ADDR_BITS-1:0]     a1_addr,
  input  logic [31:0]              a1_rdata
);

  // state  | meaning
  // IDLE   | waiting for start while the core reports ready
  // LOAD   | writing A/Q words 0..N-1 into the operand BRAMs
  // KICK   | one-cycle core_ena pulse
  // ARM    | core_rdy not yet valid, skipped for one cycle
  // WAIT   | waiting for core_rdy (or watchdog expiry)
  // READ   | result addresses 0..N-1, captures trail by one cycle
  // DONE   | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_KICK, S_ARM, S_WAIT, S_READ, S_DONE
  } state_t;

  localparam int N  = OPERAND_WIDTH / 32;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_N    = CW'(N);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CW-1:0]            r_cnt;
  logic [OPERAND_WIDTH-1:0] r_a_sh;
  logic [OPERAND_WIDTH-1:0] r_q_sh;
  logic [OPERAND_WIDTH-1:0] r_a1;
  logic                     r_err;
  logic                     w_accept;
  logic                     w_tmo_hit;

  assign w_accept = (r_state == S_IDLE) && start && core_rdy;

`ifdef MODINV_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] r_tmo;

  // Down-counter loaded on the kick, spans ARM and WAIT; terminal count flags expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo <= '0;
    end else if (r_state == S_KICK) begin
      r_tmo <= TMO_W'(TIMEOUT_CYCLES - 1);
    end else if (((r_state == S_ARM) || (r_state == S_WAIT)) && (r_tmo != '0)) begin
      r_tmo <= r_tmo - 1'b1;
    end
  end

  assign w_tmo_hit = (r_state == S_WAIT) && !core_rdy && (r_tmo == '0);
`else
  logic w_unused_tmo_param;
  assign w_unused_tmo_param = (TIMEOUT_CYCLES == 0);
  assign w_tmo_hit          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a_sh  <= '0;
      r_q_sh  <= '0;
      r_a1    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a_sh <= a_in;
            r_q_sh <= q_in;
            r_err  <= 1'b0;
            r_cnt  <= '0;
          end
        end
        S_LOAD: begin
          r_a_sh <= {32'd0, r_a_sh[OPERAND_WIDTH-1:32]};
          r_q_sh <= {32'd0, r_q_sh[OPERAND_WIDTH-1:32]};
          r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
        end
        S_WAIT: begin
          if (w_tmo_hit) r_err <= 1'b1;
        end
        S_READ: begin
          r_cnt <= r_cnt + 1'b1;
          // Data for address r arrives while r+1 is presented; word 0 ends up at the LSB.
          if (r_cnt != '0) r_a1 <= {a1_rdata, r_a1[OPERAND_WIDTH-1:32]};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_LOAD;
      S_LOAD: if (r_cnt == CNT_LAST) w_state_nxt = S_KICK;
      S_KICK: w_state_nxt = S_ARM;
      S_ARM:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (core_rdy)       w_state_nxt = S_READ;
        else if (w_tmo_hit) w_state_nxt = S_DONE;
      end
      S_READ: if (r_cnt == CNT_N) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != S_IDLE);
    done     = (r_state == S_DONE);
    err      = r_err;
    a1_out   = r_a1;
    aq_wren  = 1'b0;
    aq_addr  = '0;
    a_wdata  = '0;
    q_wdata  = '0;
    core_ena = (r_state == S_KICK);
    a1_addr  = '0;
    if (r_state == S_LOAD) begin
      aq_wren = 1'b1;
      aq_addr = r_cnt[ADDR_BITS-1:0];
      a_wdata = r_a_sh[31:0];
      q_wdata = r_q_sh[31:0];
    end
    if ((r_state == S_READ) && (r_cnt != CNT_N)) a1_addr = r_cnt[ADDR_BITS-1:0];
  end

endmodule

// File: tb/tb_modinv_operand_sequencer.sv
// Directed bench for modinv_operand_sequencer with a stub invertor core and result BRAM.
module tb_modinv_operand_sequencer;
  localparam int OW = 256;
  localparam int AB = 3;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [OW-1:0] a_in = '0;
  logic [OW-1:0] q_in = '0;
  logic          busy, done, err;
  logic [OW-1:0] a1_out;
  logic [AB-1:0] aq_addr, a1_addr;
  logic          aq_wren, core_ena, core_rdy;
  logic [31:0]   a_wdata, q_wdata;
  logic [31:0]   a1_rdata = '0;

  modinv_operand_sequencer #(.OPERAND_WIDTH(OW), .ADDR_BITS(AB), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .q_in(q_in),
    .busy(busy), .done(done), .err(err), .a1_out(a1_out),
    .aq_addr(aq_addr), .aq_wren(aq_wren), .a_wdata(a_wdata), .q_wdata(q_wdata),
    .core_ena(core_ena), .core_rdy(core_rdy), .a1_addr(a1_addr), .a1_rdata(a1_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AB-1:0] addr; logic [31:0] a; logic [31:0] q; } wr_t;
  typedef struct { logic [OW-1:0] a; logic [OW-1:0] q; logic [OW-1:0] res; int lat; bit poke; } vec_t;

  wr_t         wr_log[$];
  int          ena_cnt = 0;
  logic [31:0] mem_a1 [NW];
  int          core_lat = 1;
  bit          stub_hang = 1'b0;
  bit          stub_block = 1'b0;
  logic        stub_rdy = 1'b1;
  int          stub_cnt = 0;
  vec_t        vecs [3];
  logic [OW-1:0] prev_a1 = '0;
  int          checks = 0;
  int          failures = 0;

  // Stub core: drops ready the cycle after ena, raises it core_lat cycles later.
  always @(posedge clk) begin
    if (aq_wren) wr_log.push_back('{aq_addr, a_wdata, q_wdata});
    if (core_ena) ena_cnt <= ena_cnt + 1;
    a1_rdata <= mem_a1[a1_addr];
    if (core_ena) begin
      stub_rdy <= 1'b0;
      stub_cnt <= core_lat;
    end else if (stub_cnt > 1) begin
      stub_cnt <= stub_cnt - 1;
    end else if (stub_cnt == 1 && !stub_hang) begin
      stub_rdy <= 1'b1;
      stub_cnt <= 0;
    end
  end
  assign core_rdy = stub_rdy & ~stub_block;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string name);
    chk(name, {aq_wren, core_ena, aq_addr, a1_addr, a_wdata, q_wdata}, '0);
  endtask

  task automatic run_vec(input int i, input bit chk_prev);
    vec_t v = vecs[i];
    int c, done_c, w, wr0, ena0, rdbad, bad;
    logic [OW-1:0] got_a, got_q;
    for (int r = 0; r < NW; r++) mem_a1[r] = v.res[32*r +: 32];
    core_lat = v.lat;
    wr0  = wr_log.size();
    ena0 = ena_cnt;
    @(negedge clk);
    a_in = v.a; q_in = v.q; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a_in = ~v.a; q_in = ~v.q;
    chk("busy_after_start", busy, 1);
    if (chk_prev) chk("a1_held_during_load", a1_out, prev_a1);
    c = 1; done_c = -1; w = 10 + v.lat; rdbad = 0;
    while (done_c < 0 && c <= 60 + v.lat) begin
      start = v.poke && (c == w - 2);
      if (c >= w + 1 && c <= w + NW && a1_addr != AB'(c - w - 1)) rdbad++;
      if (done) done_c = c;
      else begin
        @(negedge clk);
        c++;
      end
    end
    start = 1'b0;
    chk("done_latency", done_c, 20 + v.lat);
    chk("err_at_done", err, 0);
    chk("a1_at_done", a1_out, v.res);
    chk("read_order", rdbad, 0);
    @(negedge clk);
    chk("busy_after_done", {busy, done}, 0);
    chk("a1_result", a1_out, v.res);
    chk_quiet("idle_quiet");
    chk("wr_count", wr_log.size() - wr0, NW);
    chk("ena_count", ena_cnt - ena0, 1);
    bad = 0; got_a = '0; got_q = '0;
    for (int k = 0; k < NW; k++) begin
      if (wr0 + k < wr_log.size()) begin
        if (wr_log[wr0 + k].addr != AB'(k)) bad++;
        got_a[32*k +: 32] = wr_log[wr0 + k].a;
        got_q[32*k +: 32] = wr_log[wr0 + k].q;
      end
    end
    chk("wr_addr_order", bad, 0);
    chk("a_words", got_a, v.a);
    chk("q_words", got_q, v.q);
    if (i < 2) begin
      chk("q_word0", got_q[31:0], 32'hffffffff);
      chk("q_word6", got_q[223:192], 32'h00000001);
    end
    prev_a1 = v.res;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, ena0;
    vecs[0] = '{256'hd3e73ccd63a5b10da308c615bb9ebd3f76e2c5fccc256fd9f629dcc956bf2382,
                256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff,
                256'h93fb26d5d199bbb7232a4b7c98e97ba9bb7530d304b5f07736ea4027bbb57ecd, 5, 1'b0};
    vecs[1] = '{256'h57b6c628a5c4e870740b2517975ace2216acbe094ac54568b53212ef45e69d22,
                256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff,
                256'hcd2af4766642d7d2f3f3f67d92c575c496772ef7d55c75eb46bd07e8d5f9a4aa, 1, 1'b0};
    vecs[2] = '{256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001,
                256'hf0f0f0f0_0f0f0f0f_aaaaaaaa_55555555_12345678_9abcdef0_deadbeef_cafef00d,
                256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888, 30, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset_status", {busy, done, err}, 0);
    chk("reset_a1", a1_out, 0);
    chk_quiet("reset_bram_ports");
    rst = 1'b0;

    run_vec(0, 1'b0);
    run_vec(1, 1'b1);
    run_vec(2, 1'b1);

    // start while the core is not ready is dropped
    wr0 = wr_log.size(); ena0 = ena_cnt;
    stub_block = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rdy_low_start_busy", busy, 0);
    chk("rdy_low_start_writes", wr_log.size() - wr0, 0);
    chk("rdy_low_start_ena", ena_cnt - ena0, 0);
    stub_block = 1'b0;

    // reset in the middle of the result read
    for (int r = 0; r < NW; r++) mem_a1[r] = vecs[0].res[32*r +: 32];
    core_lat = 3;
    @(negedge clk); a_in = vecs[0].a; q_in = vecs[0].q; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (16) @(negedge clk);
    chk("mid_read_addr", a1_addr, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_status", {busy, done, err}, 0);
    chk("rst_mid_a1", a1_out, 0);
    chk_quiet("rst_mid_bram_ports");
    rst = 1'b0;
    run_vec(0, 1'b0);

`ifdef MODINV_SEQ_TIMEOUT_EN
    begin
      int c, done_c;
      stub_hang = 1'b1;
      core_lat = 1;
      @(negedge clk); a_in = vecs[1].a; q_in = vecs[1].q; start = 1'b1;
      @(negedge clk); start = 1'b0;
      c = 1; done_c = -1;
      while (done_c < 0 && c <= 200) begin
        if (done) done_c = c;
        else begin
          @(negedge clk);
          c++;
        end
      end
      chk("tmo_done_cycle", done_c, 110);
      chk("tmo_err", err, 1);
      chk("tmo_a1_unchanged", a1_out, prev_a1);
      @(negedge clk);
      chk("tmo_busy_after", {busy, done, err}, 3'b001);
      stub_hang = 1'b0;
      repeat (3) @(negedge clk);
      run_vec(1, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
